// File: rtl/opcode_alu.sv
// opcode_alu: 16-function ALU on two 12-bit unsigned operands, 32-bit registered result.
// Latency: 1 cycle (result of op/a/b at a rising edge appears on d after that edge), 1 op per cycle.
// Backpressure: none; op 15 (HOLD) freezes d. Optional flag outputs zf/nf under `OPCODE_FLAGS_EN.
module opcode_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op,
  input  logic [11:0] a,
  input  logic [11:0] b,
`ifdef OPCODE_FLAGS_EN
  output logic        zf,
  output logic        nf,
`endif
  output logic [31:0] d
);

  localparam logic [3:0] OP_HOLD = 4'd15;

  // Zero-extended operands so every arithmetic op is evaluated at full result width.
  logic [31:0] a_ext;
  logic [31:0] b_ext;
  assign a_ext = {20'b0, a};
  assign b_ext = {20'b0, b};

  // Rotate amount is b mod 12; doubling a and shifting exposes the rotated word in the top half.
  logic [3:0]  rot_amt;
  logic [23:0] rot_dbl;
  assign rot_amt = 4'(b % 12'd12);
  assign rot_dbl = {a, a} << rot_amt;

  // Division by zero is guarded so the divider never sees a zero divisor result path.
  logic [11:0] quo;
  logic [11:0] rem;
  assign quo = (b == 12'd0) ? 12'd0 : (a / b);
  assign rem = (b == 12'd0) ? a : (a % b);

  logic [31:0] nxt;

  // Decode every opcode into the value that d takes on the next edge.
  always_comb begin
    nxt = d;
    case (op)
      4'd0:  nxt = a_ext + b_ext;
      4'd1:  nxt = a_ext - b_ext;
      4'd2:  nxt = a_ext * b_ext;
      4'd3:  nxt = (b == 12'd0) ? 32'hFFFF_FFFF : {20'b0, quo};
      4'd4:  nxt = {20'b0, rem};
      4'd5:  nxt = {20'b0, a & b};
      4'd6:  nxt = {20'b0, a | b};
      4'd7:  nxt = {20'b0, a ^ b};
      4'd8:  nxt = {20'b0, ~a};
      4'd9:  nxt = a_ext << b[4:0];
      4'd10: nxt = {20'b0, a >> b[3:0]};
      4'd11: nxt = {20'b0, rot_dbl[23:12]};
      4'd12: nxt = {31'b0, (a == b)};
      4'd13: nxt = {31'b0, (a < b)};
      4'd14: nxt = {8'b0, a, b};
      4'd15: nxt = d;
    endcase
  end

  // Result register: cleared asynchronously, frozen during HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= 32'd0;
    end else if (op != OP_HOLD) begin
      d <= nxt;
    end
  end

`ifdef OPCODE_FLAGS_EN
  // Flags track the value being loaded into d and freeze along with it during HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      nf <= 1'b0;
    end else if (op != OP_HOLD) begin
      zf <= (nxt == 32'd0);
      nf <= nxt[31];
    end
  end
`endif

endmodule

// File: tb/tb_opcode_alu.sv
// Testbench for opcode_alu: directed vectors followed by randomized ops against an arithmetic model.
module tb_opcode_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op;
  logic [11:0] a;
  logic [11:0] b;
  logic [31:0] d;
`ifdef OPCODE_FLAGS_EN
  logic        zf;
  logic        nf;
`endif

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_d   = 32'd0;
  logic        m_zf  = 1'b0;
  logic        m_nf  = 1'b0;

  opcode_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef OPCODE_FLAGS_EN
    .zf    (zf),
    .nf    (nf),
`endif
    .d     (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input int o, input longint x, input longint y,
                                          input logic [31:0] prev);
    longint r;
    longint s;
    r = 0;
    case (o)
      0:  r = x + y;
      1:  r = x - y;
      2:  r = x * y;
      3:  r = (y == 0) ? 64'hFFFF_FFFF : x / y;
      4:  r = (y == 0) ? x : x % y;
      5:  r = x & y;
      6:  r = x | y;
      7:  r = x ^ y;
      8:  r = 4095 - x;
      9:  begin s = y % 32; r = x; for (longint k = 0; k < s; k++) r = (r * 2) % 64'h1_0000_0000; end
      10: begin s = y % 16; r = 0; if (s < 12) r = x / (64'd1 << s); end
      11: begin s = y % 12; r = x; for (longint k = 0; k < s; k++) r = ((r * 2) % 4096) + (r / 2048); end
      12: r = (x == y) ? 1 : 0;
      13: r = (x < y) ? 1 : 0;
      14: r = x * 4096 + y;
      default: r = longint'(prev);
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk(tag, d, m_d);
`ifdef OPCODE_FLAGS_EN
    chk({tag, ".zf"}, {31'b0, zf}, {31'b0, m_zf});
    chk({tag, ".nf"}, {31'b0, nf}, {31'b0, m_nf});
`endif
  endtask

  // Apply one op at the negedge, check the result just after the following posedge.
  task automatic step(input string tag, input logic [3:0] o, input logic [11:0] x, input logic [11:0] y);
    logic [31:0] e;
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    e = ref_alu(int'(o), longint'(x), longint'(y), m_d);
    @(posedge clk);
    #1;
    if (o != 4'd15) begin
      m_d  = e;
      m_zf = (e == 32'd0);
      m_nf = e[31];
    end
    chk_all(tag);
  endtask

  // Mid-cycle reset pulse; d must clear without waiting for a clock edge.
  task automatic mid_reset(input logic [3:0] o, input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    #2 rst_n = 1'b0;
    #1;
    m_d = 32'd0; m_zf = 1'b0; m_nf = 1'b0;
    chk_all("mid_reset");
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  ro;
    logic [11:0] rx;
    logic [11:0] ry;

    rst_n = 1'b0;
    op = 4'd0; a = 12'd0; b = 12'd0;
    #3;
    chk_all("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // reset in flight: load something, then clear mid-cycle, then first edge loads 520
    step("pre_reset_add", 4'd0, 12'd65, 12'd8);
    mid_reset(4'd2, 12'd65, 12'd8);
    step("post_reset_mul", 4'd2, 12'd65, 12'd8);

    // sweep ops 0..14 with a=65, b=8
    for (int i = 0; i < 15; i++) begin
      step($sformatf("sweep_op%0d", i), 4'(i), 12'd65, 12'd8);
    end

    // divide by zero
    step("div0", 4'd3, 12'd65, 12'd0);
    step("mod0", 4'd4, 12'd65, 12'd0);

    // sign and compare
    step("sub_neg", 4'd1, 12'd8, 12'd65);
    step("ltu", 4'd13, 12'd8, 12'd65);
    step("eq_max", 4'd12, 12'd4095, 12'd4095);

    // extremes
    step("mul_max", 4'd2, 12'd4095, 12'd4095);
    step("add_max", 4'd0, 12'd4095, 12'd4095);
    step("shl_31", 4'd9, 12'd4095, 12'd31);
    step("rol_13", 4'd11, 12'h801, 12'd13);
    step("shr_12", 4'd10, 12'd4095, 12'd12);
    step("shr_hi", 4'd10, 12'd4095, 12'h013);
    step("not_0", 4'd8, 12'd0, 12'd5);

    // hold
    step("hold_load", 4'd0, 12'd65, 12'd8);
    step("hold1", 4'd15, 12'd1, 12'd2);
    step("hold2", 4'd15, 12'd4095, 12'd0);
    step("hold3", 4'd15, 12'd300, 12'd77);

    // hold right after reset keeps cleared flags
    mid_reset(4'd15, 12'd0, 12'd0);
    step("hold_after_reset", 4'd15, 12'd9, 12'd9);

    // randomized ops
    for (int i = 0; i < 600; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = 12'($urandom_range(0, 4095));
      ry = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) ry = 12'd0;
      if ($urandom_range(0, 9) == 0) ry = rx;
      if ($urandom_range(0, 9) == 0) ry = 12'($urandom_range(0, 40));
      step($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry);
      if (i % 150 == 149) mid_reset(ro, rx, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
